// File: rtl/twiddle_angle_gen_if.sv
// Angle stream bundle between the stage controller and the CORDIC angle input.
// Optional o_neg sideband exists only when TWIDDLE_FOLD_EN is defined.
interface twiddle_angle_gen_if #(
   parameter int DATA_W = 32,
   parameter int M_MAX  = 10
);
   localparam int LOG_W = $clog2(M_MAX + 1);

   logic              i_start;
   logic [LOG_W-1:0]  i_log_n;
   logic              i_ready;
   logic              o_valid;
   logic [DATA_W-1:0] o_angle;
   logic [M_MAX-1:0]  o_index;
   logic              o_last;
   logic              o_busy;
   logic              o_done;
`ifdef TWIDDLE_FOLD_EN
   logic              o_neg;
`endif

   modport master (
      output i_start, i_log_n, i_ready,
`ifdef TWIDDLE_FOLD_EN
      input  o_neg,
`endif
      input  o_valid, o_angle, o_index, o_last, o_busy, o_done
   );

   modport slave (
      input  i_start, i_log_n, i_ready,
`ifdef TWIDDLE_FOLD_EN
      output o_neg,
`endif
      output o_valid, o_angle, o_index, o_last, o_busy, o_done
   );
endinterface

// File: rtl/twiddle_angle_gen.sv
// Streams angle_k = -k*pi/2^M from a guarded phase accumulator, one entry per accepted cycle.
// TWIDDLE_FOLD_EN folds angles below -pi/2 by +pi and flags them on o_neg.
module twiddle_angle_gen #(
   parameter int DATA_W  = 32,
   parameter int FRAC_W  = 16,
   parameter int GUARD_W = 16,
   parameter int M_MAX   = 10
) (
   input logic                i_clk,
   input logic                i_rst_n,
   twiddle_angle_gen_if.slave bus
);
   localparam int     LOG_W    = $clog2(M_MAX + 1);
   localparam int     ACC_W    = FRAC_W + GUARD_W + 3;
   localparam int     EXT_W    = ACC_W + DATA_W;
   localparam real    PI_R     = 3.14159265358979323846;
   localparam longint PI_EXT_L = longint'(PI_R * (2.0 ** (FRAC_W + GUARD_W)));
   localparam logic [ACC_W-1:0] PI_EXT = ACC_W'(PI_EXT_L);
   localparam logic [ACC_W-1:0] HALF   = ACC_W'(1) << (GUARD_W - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] step;
   logic [ACC_W-1:0] acc_nx;
   logic [M_MAX-1:0] k;
   logic [M_MAX-1:0] k_nx;
   logic [M_MAX-1:0] last_idx;
   logic [M_MAX-1:0] start_last;
   logic [M_MAX:0]   span;
   logic [LOG_W-1:0] m_sel;

   function automatic logic [DATA_W-1:0] angle_of(input logic [ACC_W-1:0] a);
      logic [ACC_W-1:0]        mag;
      logic signed [EXT_W-1:0] ext;
`ifdef TWIDDLE_FOLD_EN
      if (a > (PI_EXT >> 1)) begin
         // folded magnitude truncates rather than rounds
         mag = (PI_EXT - a) >> GUARD_W;
         ext = $signed({{DATA_W{1'b0}}, mag});
         return ext[DATA_W-1:0];
      end
`endif
      mag = (a + HALF) >> GUARD_W;
      ext = -$signed({{DATA_W{1'b0}}, mag});
      return ext[DATA_W-1:0];
   endfunction

   always_comb begin
      m_sel      = (bus.i_log_n > LOG_W'(M_MAX)) ? LOG_W'(M_MAX) : bus.i_log_n;
      span       = (M_MAX + 1)'(1) << m_sel;
      start_last = M_MAX'(span - (M_MAX + 1)'(1));
      acc_nx     = acc + step;
      k_nx       = k + M_MAX'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         acc         <= '0;
         step        <= '0;
         k           <= '0;
         last_idx    <= '0;
         bus.o_valid <= 1'b0;
         bus.o_angle <= '0;
         bus.o_index <= '0;
         bus.o_last  <= 1'b0;
         bus.o_busy  <= 1'b0;
         bus.o_done  <= 1'b0;
`ifdef TWIDDLE_FOLD_EN
         bus.o_neg   <= 1'b0;
`endif
      end else begin
         bus.o_done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_start) begin
                  acc         <= '0;
                  k           <= '0;
                  step        <= PI_EXT >> m_sel;
                  last_idx    <= start_last;
                  bus.o_valid <= 1'b1;
                  bus.o_busy  <= 1'b1;
                  bus.o_angle <= '0;
                  bus.o_index <= '0;
                  bus.o_last  <= (start_last == '0);
`ifdef TWIDDLE_FOLD_EN
                  bus.o_neg   <= 1'b0;
`endif
                  state       <= RUN;
               end
            end
            RUN: begin
               if (bus.o_valid && bus.i_ready) begin
                  if (bus.o_last) begin
                     bus.o_valid <= 1'b0;
                     bus.o_busy  <= 1'b0;
                     bus.o_last  <= 1'b0;
                     bus.o_done  <= 1'b1;
                     state       <= IDLE;
                  end else begin
                     acc         <= acc_nx;
                     k           <= k_nx;
                     bus.o_angle <= angle_of(acc_nx);
                     bus.o_index <= k_nx;
                     bus.o_last  <= (k_nx == last_idx);
`ifdef TWIDDLE_FOLD_EN
                     bus.o_neg   <= (acc_nx > (PI_EXT >> 1));
`endif
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
